// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller.
//   rx_state_e      : controller FSM states (OFF / LISTEN / HOLD)
//   STAT_*          : bit positions inside the 8-bit status register
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_LISTEN = 2'd1,
        ST_HOLD   = 2'd2
    } rx_state_e;

    localparam int unsigned STAT_W          = 8;
    localparam int unsigned STAT_DATA_AVAIL = 7;
    localparam int unsigned STAT_OVERFLOW   = 6;
    localparam int unsigned STAT_STOP_ERR   = 5;
    localparam int unsigned STAT_BREAK_ERR  = 4;
    localparam int unsigned STAT_PARITY_ERR = 3;
    localparam int unsigned STAT_EMPTY      = 2;
    localparam int unsigned STAT_FULL       = 1;
    localparam int unsigned STAT_RD_ERR     = 0;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   push, wdata    : write request and data (dropped when full unless popping)
//   pop            : read request (ignored when empty)
//   head_c         : combinational view of the head entry
//   count          : registered fill level
//   count_next_c   : fill level after this cycle's push/pop
//   full, empty    : registered fill flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic [DATA_SIZE-1:0]               wdata,
    output logic [DATA_SIZE-1:0]               head_c,
    output logic [$clog2(FIFO_DEPTH):0]        count,
    output logic [$clog2(FIFO_DEPTH):0]        count_next_c,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // A push into a full FIFO only lands when a pop frees the slot in the same cycle
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head_c  = mem[rd_ptr];

    // Next fill level
    always_comb begin
        count_next_c = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next_c = CNT_W'(count + 1'b1);
            2'b01:   count_next_c = CNT_W'(count - 1'b1);
            default: count_next_c = count;
        endcase
    end

    // Pointers and flags; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (pop_ok)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(FIFO_DEPTH));
            empty <= (count_next_c == '0);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the UART receiver, buffers good frames,
// keeps sticky error status and serves host pops.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   rx_en                   : receive enable
//   serial_in               : synchronized line, used for overflow edge detect in HOLD
//   rx_done, rx_data        : receiver frame-complete pulse and data
//   parity/stop/break_error : receiver error pulses qualified by rx_done
//   rx_start_n              : receiver start permit, low only while listening
//   rd_en, rd_data, rd_valid: host pop request, popped data, data-valid pulse
//   clr_status              : clears sticky status bits (a same-cycle set wins)
//   rx_irq_en, err_irq_en   : interrupt source enables
//   status                  : {data_avail, overflow, stop_err, break_err, parity_err, empty, full, rd_err}
//   irq                     : level interrupt
// Build option: define UART_RX_CTRL_IRQ_EN to include the interrupt logic;
// otherwise irq is tied low.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_en,
    input  logic                 serial_in,
    input  logic                 rx_done,
    input  logic [DATA_SIZE-1:0] rx_data,
    input  logic                 parity_error,
    input  logic                 stop_error,
    input  logic                 break_error,
    output logic                 rx_start_n,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 clr_status,
    input  logic                 rx_irq_en,
    input  logic                 err_irq_en,
    output logic [STAT_W-1:0]    status,
    output logic                 irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_e            state;
    rx_state_e            state_next;
    logic                 start_n_next;

    logic [DATA_SIZE-1:0] head_c;
    logic [CNT_W-1:0]     fifo_count_unused;
    logic [CNT_W-1:0]     count_next_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 full_next;
    logic                 empty_next;

    logic [1:0]           sin_hist;
    logic                 fall_edge;

    logic                 capture;
    logic                 err_any;
    logic                 push_req;
    logic                 pop_req;
    logic                 push;
    logic                 ovf_set;

    logic                 ovf_q, stop_q, brk_q, par_q, rderr_q;
    logic                 ovf_next, stop_next, brk_next, par_next, rderr_next;
    logic [STAT_W-1:0]    status_next;

    uart_rx_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .pop          (pop_req),
        .wdata        (rx_data),
        .head_c       (head_c),
        .count        (fifo_count_unused),
        .count_next_c (count_next_c),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    assign full_next  = (count_next_c == CNT_W'(FIFO_DEPTH));
    assign empty_next = (count_next_c == '0);

    // Serial line history; idles high so reset cannot fake a falling edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sin_hist <= 2'b11;
        else          sin_hist <= {sin_hist[0], serial_in};
    end

    // A new start bit while held off means the receiver line is being lost
    assign fall_edge = (sin_hist == 2'b10);

    // FSM state register and registered start permit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_OFF;
            rx_start_n <= 1'b1;
        end else begin
            state      <= state_next;
            rx_start_n <= start_n_next;
        end
    end

    // FSM next state; full decisions use the post-update count so the permit tracks it in one cycle
    always_comb begin
        state_next   = state;
        start_n_next = 1'b1;
        case (state)
            ST_OFF:    if (rx_en) state_next = full_next ? ST_HOLD : ST_LISTEN;
            ST_LISTEN: if (full_next) state_next = ST_HOLD;
            ST_HOLD:   if (!full_next) state_next = ST_LISTEN;
            default:   state_next = ST_OFF;
        endcase
        if (!rx_en) state_next = ST_OFF;
        start_n_next = (state_next != ST_LISTEN);
    end

    // Frame capture, pop qualification and sticky status update
    always_comb begin
        capture    = rx_done && (state != ST_OFF);
        err_any    = parity_error || stop_error || break_error;
        push_req   = capture && !err_any;
        pop_req    = rd_en && !fifo_empty;
        push       = push_req && (!fifo_full || pop_req);
        ovf_set    = (push_req && fifo_full && !pop_req) || ((state == ST_HOLD) && fall_edge);

        ovf_next   = (ovf_q   && !clr_status) || ovf_set;
        stop_next  = (stop_q  && !clr_status) || (capture && stop_error);
        brk_next   = (brk_q   && !clr_status) || (capture && break_error);
        par_next   = (par_q   && !clr_status) || (capture && parity_error);
        rderr_next = (rderr_q && !clr_status) || (rd_en && fifo_empty);

        status_next                  = '0;
        status_next[STAT_DATA_AVAIL] = !empty_next;
        status_next[STAT_OVERFLOW]   = ovf_next;
        status_next[STAT_STOP_ERR]   = stop_next;
        status_next[STAT_BREAK_ERR]  = brk_next;
        status_next[STAT_PARITY_ERR] = par_next;
        status_next[STAT_EMPTY]      = empty_next;
        status_next[STAT_FULL]       = full_next;
        status_next[STAT_RD_ERR]     = rderr_next;
    end

    // Registered status, sticky bits and pop outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q    <= 1'b0;
            stop_q   <= 1'b0;
            brk_q    <= 1'b0;
            par_q    <= 1'b0;
            rderr_q  <= 1'b0;
            status   <= STAT_W'(8'h04);
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            ovf_q    <= ovf_next;
            stop_q   <= stop_next;
            brk_q    <= brk_next;
            par_q    <= par_next;
            rderr_q  <= rderr_next;
            status   <= status_next;
            rd_valid <= pop_req;
            if (pop_req) rd_data <= head_c;
        end
    end

`ifdef UART_RX_CTRL_IRQ_EN
    logic irq_next;

    // Interrupt follows the registered status by one cycle
    assign irq_next = (rx_irq_en && status[STAT_DATA_AVAIL]) ||
                      (err_irq_en && (status[STAT_OVERFLOW]   || status[STAT_STOP_ERR] ||
                                      status[STAT_BREAK_ERR]  || status[STAT_PARITY_ERR] ||
                                      status[STAT_RD_ERR]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= irq_next;
    end
`else
    logic irq_en_unused;

    assign irq_en_unused = rx_irq_en | err_irq_en;
    assign irq           = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. Gates the receiver with `rx_start_n` and captures each completed frame. Error-free frames go into a small FIFO. Receiver error pulses become sticky status bits. The block presents an 8-bit status register, a host pop interface and an optional interrupt. It sits between `uart_receiver` and the host register/bus logic.

## Interface
Parameters:
- `DATA_SIZE`, 8, frame data width.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx_en`  in  1  receive enable from host config.
- `serial_in`  in  1  the synchronized serial line that also feeds the receiver; used for overflow detection only.
- `rx_done`  in  1  receiver end-of-frame pulse.
- `rx_data`  in  DATA_SIZE  receiver `data_out`.
- `parity_error`, `stop_error`, `break_error`  in  1 each  receiver error pulses, qualified by `rx_done`.
- `rx_start_n`  out  1  receiver start permit; active-low.
- `rd_en`  in  1  host pop request, single-cycle pulse.
- `rd_data`  out  DATA_SIZE  popped data.
- `rd_valid`  out  1  `rd_data` valid pulse.
- `clr_status`  in  1  clears all sticky status bits.
- `rx_irq_en`, `err_irq_en`  in  1 each  interrupt source enables.
- `status`  out  8  status register: {data_avail, overflow, stop_err, break_err, parity_err, empty, full, rd_err}.
- `irq`  out  1  level interrupt.

## Operation
FSM states are OFF, LISTEN and HOLD. `rx_start_n` is 0 only in LISTEN.
- OFF: entered on reset and whenever `rx_en`=0, from any state.
  - OFF→LISTEN when `rx_en` and FIFO not full.
  - OFF→HOLD when `rx_en` and FIFO full.
- LISTEN→HOLD when the FIFO count reaches `FIFO_DEPTH`.
- HOLD→LISTEN when the count drops below `FIFO_DEPTH`.
- Frame capture happens on `rx_done`=1 in LISTEN or HOLD:
  - If any error input is set, the frame is not pushed. Each asserted error input sets its sticky bit.
  - If no error input is set, `rx_data` is pushed.
  - A push while the FIFO is full and no pop occurs in the same cycle is dropped and sets `overflow`.
- `rx_done` in OFF is ignored: no push, no status change.
- Overflow detection: in HOLD, a 1→0 transition on `serial_in` sets `overflow`. A 2-bit `serial_in` history register provides the edge detect.
- Pop: `rd_en` with FIFO not empty presents the head on `rd_data` and asserts `rd_valid`.
- `rd_en` with FIFO empty sets sticky `rd_err`. `rd_valid` stays 0 and `rd_data` holds its value.
- Simultaneous push and pop: both take effect and the count is unchanged. This holds when full as well; that case is not an overflow.
- Status bits:
  - `data_avail` = ~empty.
  - `empty` and `full` are derived from the registered count.
  - Sticky bits are `overflow`, `stop_err`, `break_err`, `parity_err` and `rd_err`. `clr_status` clears them all.
  - When a set and `clr_status` occur in the same cycle, the set wins.
- Count width is `$clog2(FIFO_DEPTH)+1`. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - `rx_start_n`=1.
  - `rd_data`=0, `rd_valid`=0.
  - `status`=8'b0000_0100.
  - `irq`=0.
  - FSM=OFF, FIFO empty.
- `rx_done` at cycle N gives updated count, `status` and sticky bits at N+1. The FIFO-full transition to HOLD, and hence `rx_start_n`=1, also occurs at N+1.
- `rd_en` at cycle N gives `rd_data`/`rd_valid` at N+1, and the decremented count and LISTEN re-entry at N+1.
- `rx_en` falling at N gives `rx_start_n`=1 at N+1. A frame already in the receiver completes and is discarded.
- `irq` is registered and follows its sources by one cycle.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `UART_RX_CTRL_IRQ_EN` defined: `irq` = (`rx_irq_en` & `data_avail`) | (`err_irq_en` & (`overflow`|`stop_err`|`break_err`|`parity_err`|`rd_err`)), registered.
- Not defined: the interrupt logic is removed. `irq` is tied to 0, and `rx_irq_en`/`err_irq_en` are unused.

## Structure
- Package `uart_pkg` holds:
  - the state enum typedef for OFF/LISTEN/HOLD;
  - localparams for the status bit indices (7 down to 0 as listed under `status`).
- Sub-module `uart_rx_fifo` is a synchronous FIFO with push, pop, full, empty and count outputs. The controller instantiates it once.

## Test plan
- Reset, then `rx_en`=1 → `rx_start_n`=0 within 1 cycle, and `status`=8'h04.
- Good frame 8'hA5 (`rx_done`, no errors), then `rd_en` → `status`=8'h80, then `rd_data`=8'hA5 with `rd_valid`=1, and `status` back to 8'h04.
- Frame with `parity_error`=1 → no push, and `status`=8'h0C. Then `clr_status` → `status`=8'h04.
- Four good frames (depth 4) → `full`=1 and `rx_start_n`=1. A `serial_in` 1→0 edge then sets `overflow` (`status`=8'hC2). One pop → `rx_start_n`=0.
- `rd_en` on empty FIFO → `rd_valid`=0 and `status`=8'h05. With the macro defined and `err_irq_en`=1 → `irq`=1 one cycle later.
- `rx_en` dropped, then `rx_done` with data 8'h3C → no push, `status` unchanged, `rx_start_n`=1.
